// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, line levels and parity-type encodings.
// Used by the transmitter today and by the receiver parity checker later.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = IDLE,
        StStart  = START,
        StData   = DATA,
        StParity = PARITY,
        StStop   = STOP
    } tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator over a data word; even or odd selectable.
// Shared between the transmitter and the receiver parity checker.
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  parity_o
);

    // Odd parity is the complement of the plain XOR reduction.
    assign parity_o = (^data_i) ^ (par_typ_i == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Each rising edge of i_clk is one bit period; inputs are shadowed when a frame starts.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_tx_out,
    output logic                  o_busy
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [CntW-1:0]       cnt_inc;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  parity_bit;

    uart_tx_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_calc (
        .data_i   (data_q),
        .par_typ_i(par_typ_q),
        .parity_o (parity_bit)
    );

    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            StIdle: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
                if (i_data_valid) begin
                    data_d    = i_p_data;
                    par_en_d  = i_par_en;
                    par_typ_d = i_par_typ;
                    tx_d      = START_BIT;
                    busy_d    = 1'b1;
                    state_d   = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                tx_d    = data_q[0];
                state_d = StData;
            end
            StData: begin
                // Counter holds the index of the bit currently on the line.
                if (cnt_q == LastIdx) begin
                    cnt_d = '0;
                    if (par_en_q) begin
                        tx_d    = parity_bit;
                        state_d = StParity;
                    end else begin
                        tx_d    = STOP_BIT;
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    tx_d  = data_q[cnt_inc];
                end
            end
            StParity: begin
                tx_d    = STOP_BIT;
                state_d = StStop;
            end
            StStop: begin
                tx_d    = STOP_BIT;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                tx_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign o_tx_out = tx_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed and random frames checked against a bit-list frame model,
// with the bit clock derived from a reference clock by a programmable divide ratio.
module tb_uart_tx_frame;

    logic       ref_clk = 1'b0;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int  div_ratio = 2;
    int  div_cnt = 0;
    int  tests = 0;
    int  fails = 0;
    bit  exp_q[$];
    time t_prev;

    uart_tx_frame #(
        .DATA_WIDTH(8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_p_data    (p_data),
        .i_data_valid(data_valid),
        .i_par_en    (par_en),
        .i_par_typ   (par_typ),
        .o_tx_out    (tx_out),
        .o_busy      (busy)
    );

    always #5 ref_clk = ~ref_clk;

    // Stand-in for the clock divider: rising edge every div_ratio reference clocks.
    always @(posedge ref_clk) begin
        if (div_cnt >= div_ratio - 1) div_cnt = 0;
        else div_cnt = div_cnt + 1;
        clk = (div_cnt < div_ratio / 2);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model: the frame is simply the list of line levels, one per bit period.
    task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt);
        int ones = 0;
        exp_q = {};
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (pe) exp_q.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
        exp_q.push_back(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input int change_at, input int period);
        build_frame(d, pe, pt);
        @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        @(posedge clk);
        t_prev = $time;
        #1;
        data_valid = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin
                @(posedge clk);
                if (period > 0) check("bit_period", int'($time - t_prev), period);
                t_prev = $time;
                #1;
            end
            check($sformatf("tx_bit%0d", k), int'(tx_out), int'(exp_q[k]));
            check($sformatf("busy_bit%0d", k), int'(busy), 1);
            if (k == change_at) begin
                p_data  = 8'hFF;
                par_typ = ~pt;
                par_en  = ~pe;
            end
        end
        @(posedge clk);
        #1;
        check("tx_after", int'(tx_out), 1);
        check("busy_after", int'(busy), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        p_data     = 8'h00;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        repeat (3) @(posedge ref_clk);
        #1;
        check("rst_tx", int'(tx_out), 1);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_tx", int'(tx_out), 1);
        check("idle_busy", int'(busy), 0);

        // Directed frames.
        send_frame(8'hA5, 1'b0, 1'b0, -1, 0);
        send_frame(8'hA5, 1'b1, 1'b0, -1, 0);
        send_frame(8'hA5, 1'b1, 1'b1, -1, 0);
        send_frame(8'h07, 1'b1, 1'b0, 3, 0);

        // Reset mid-DATA: line and busy must drop without a clock edge.
        @(negedge clk);
        p_data     = 8'h5A;
        par_en     = 1'b0;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", int'(tx_out), 1);
        check("midrst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, -1, 0);

        // Valid held high: frames back to back with one idle period between.
        build_frame(8'h55, 1'b0, 1'b0);
        @(negedge clk);
        p_data     = 8'h55;
        par_en     = 1'b0;
        data_valid = 1'b1;
        for (int n = 0; n < 36; n++) begin
            int p;
            @(posedge clk);
            #1;
            p = n % 11;
            if (n / 11 <= 2 && p < 10) begin
                check($sformatf("hold_tx%0d", n), int'(tx_out), int'(exp_q[p]));
                check($sformatf("hold_busy%0d", n), int'(busy), 1);
            end else begin
                check($sformatf("hold_tx%0d", n), int'(tx_out), 1);
                check($sformatf("hold_busy%0d", n), int'(busy), 0);
            end
            if (n == 29) data_valid = 1'b0;
        end

        // Random frames with random idle gaps.
        for (int r = 0; r < 12; r++) begin
            logic [7:0] d;
            logic       pe;
            logic       pt;
            d  = 8'($urandom_range(0, 255));
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame(d, pe, pt, int'($urandom_range(0, 12)), 0);
        end

        // Slow bit clock from an odd divide ratio.
        @(negedge clk);
        div_ratio = 5;
        repeat (3) @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), -1, 50);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
